// File: rtl/load_extend_pipe_pkg.sv
// Shared definitions for the load extend pipeline: access size encoding and
// the alignment rule shared with the control unit decode.
package load_extend_pipe_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } size_e;

    // Control fields carried alongside the aligned data through stage 1
    typedef struct packed {
        size_e size;
        logic  sign;
        logic  misalign;
    } s1_ctrl_t;

    // An access is illegal when its field is not naturally aligned, or when a
    // dword is requested on a 32-bit datapath.
    function automatic logic access_misaligned(size_e size, logic [2:0] offset,
                                               logic narrow_bus);
        logic bad;
        bad = 1'b0;
        unique case (size)
            SIZE_BYTE:  bad = 1'b0;
            SIZE_HALF:  bad = offset[0];
            SIZE_WORD:  bad = (offset[1:0] != 2'b00);
            SIZE_DWORD: bad = narrow_bus || (offset != 3'b000);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extend_pipe_if.sv
// Load-data handshake bundle: upstream beat (data, offset, size, sign) and
// downstream extended result with misalign flag and error count.
interface load_extend_pipe_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ERR_CNT_W = 8
);
    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_data;
    logic [OFF_W-1:0]     in_offset;
    logic [1:0]           in_size;
    logic                 in_sign;

    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_data;
    logic                 out_misalign;
    logic [ERR_CNT_W-1:0] err_count;

    // Producer/consumer side of the pipeline
    modport master (
        output in_valid, in_data, in_offset, in_size, in_sign, out_ready,
        input  in_ready, out_valid, out_data, out_misalign, err_count
    );

    // Pipeline side
    modport slave (
        input  in_valid, in_data, in_offset, in_size, in_sign, out_ready,
        output in_ready, out_valid, out_data, out_misalign, err_count
    );

endinterface

// File: rtl/load_extend_pipe_extend_field.sv
// Combinational sign/zero extender: keeps the low byte/half/word/dword of an
// aligned field and fills the upper bits with the field MSB or zero.
module extend_field
    import load_extend_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] field,
    input  size_e             size,
    input  logic              sign,
    output logic [DATA_W-1:0] result
);

    localparam logic [DATA_W-1:0] MASK_BYTE = DATA_W'(8'hFF);
    localparam logic [DATA_W-1:0] MASK_HALF = DATA_W'(16'hFFFF);
    localparam logic [DATA_W-1:0] MASK_WORD = DATA_W'(32'hFFFF_FFFF);
    localparam logic [DATA_W-1:0] MASK_FULL = '1;

    logic [DATA_W-1:0] mask;
    logic              top_bit;
    logic [DATA_W-1:0] fill;

    // Select field mask and its MSB; a full-width field passes unchanged
    always_comb begin
        mask    = MASK_FULL;
        top_bit = field[DATA_W-1];
        unique case (size)
            SIZE_BYTE: begin
                mask    = MASK_BYTE;
                top_bit = field[7];
            end
            SIZE_HALF: begin
                mask    = MASK_HALF;
                top_bit = field[15];
            end
            SIZE_WORD: begin
                mask    = MASK_WORD;
                top_bit = field[31];
            end
            SIZE_DWORD: begin
                mask    = MASK_FULL;
                top_bit = field[DATA_W-1];
            end
            default: begin
                mask    = MASK_FULL;
                top_bit = field[DATA_W-1];
            end
        endcase
    end

    assign fill   = {DATA_W{sign & top_bit}};
    assign result = (field & mask) | (fill & ~mask);

endmodule

// File: rtl/load_extend_pipe.sv
// Two-stage valid/ready load data pipeline: stage 1 aligns the field and
// checks alignment, stage 2 extends it; misaligned beats are counted.
module load_extend_pipe
    import load_extend_pipe_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    load_extend_pipe_if.slave  bus
);

    logic                 s1_valid;
    logic [DATA_W-1:0]    s1_data;
    s1_ctrl_t             s1_ctrl;
    s1_ctrl_t             in_ctrl;
    logic [DATA_W-1:0]    in_aligned;

    logic                 s2_valid;
    logic                 s2_ready;
    logic [DATA_W-1:0]    s2_data;
    logic                 s2_misalign;
    logic [DATA_W-1:0]    ext_data;

    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 out_fire;

    // Handshake: no skid buffer, ready ripples back combinationally
    assign s2_ready     = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_ready;
    assign out_fire     = s2_valid && bus.out_ready;

    // Decode incoming beat
    always_comb begin
        in_ctrl          = '0;
        in_ctrl.size     = size_e'(bus.in_size);
        in_ctrl.sign     = bus.in_sign;
        in_ctrl.misalign = access_misaligned(size_e'(bus.in_size),
                                             3'(bus.in_offset),
                                             DATA_W == 32);
    end

    assign in_aligned = bus.in_data >> {bus.in_offset, 3'b000};

    // Stage 1: aligned field and control
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_ctrl  <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data <= in_aligned;
                s1_ctrl <= in_ctrl;
            end
        end
    end

    extend_field #(
        .DATA_W (DATA_W)
    ) u_extend (
        .field  (s1_data),
        .size   (s1_ctrl.size),
        .sign   (s1_ctrl.sign),
        .result (ext_data)
    );

    // Stage 2: extended result; payload only moves with a valid beat so the
    // output holds its last value while idle or stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid    <= 1'b0;
            s2_data     <= '0;
            s2_misalign <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data     <= s1_ctrl.misalign ? '0 : ext_data;
                s2_misalign <= s1_ctrl.misalign;
            end
        end
    end

    // Saturating count of delivered misaligned beats
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else if (out_fire && s2_misalign && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign bus.out_valid    = s2_valid;
    assign bus.out_data     = s2_data;
    assign bus.out_misalign = s2_misalign;
    assign bus.err_count    = err_cnt_q;

endmodule

// File: tb/tb_load_extend_pipe.sv
// Scoreboard bench for load_extend_pipe: a 32-bit instance with a 2-bit error
// counter and a 64-bit instance with the default counter width.
`timescale 1ns/1ps
module tb_load_extend_pipe;

    typedef struct {
        logic [63:0] data;
        logic        mis;
    } exp_t;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;
    int   acc32;

    exp_t q32[$];
    exp_t q64[$];

    load_extend_pipe_if #(.DATA_W(32), .ERR_CNT_W(2)) if32();
    load_extend_pipe_if #(.DATA_W(64), .ERR_CNT_W(8)) if64();

    load_extend_pipe #(.DATA_W(32), .ERR_CNT_W(2)) u32 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if32)
    );

    load_extend_pipe #(.DATA_W(64), .ERR_CNT_W(8)) u64 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one beat to the 32-bit instance; optionally record its expected result
    task automatic send32(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                          input logic sg, input logic [31:0] ed, input logic em, input bit push);
        int n;
        exp_t e;
        if32.in_valid  = 1'b1;
        if32.in_data   = d;
        if32.in_offset = off;
        if32.in_size   = sz;
        if32.in_sign   = sg;
        n = 0;
        @(negedge clk);
        while (!if32.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!if32.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send32_timeout: in_ready=0 after %0d cycles, required 1", n);
        end else if (push) begin
            e.data = {32'h0, ed};
            e.mis  = em;
            q32.push_back(e);
        end
        @(posedge clk);
        #1;
        if32.in_valid = 1'b0;
        acc32++;
    endtask

    task automatic send64(input logic [63:0] d, input logic [2:0] off, input logic [1:0] sz,
                          input logic sg, input logic [63:0] ed, input logic em);
        int n;
        exp_t e;
        if64.in_valid  = 1'b1;
        if64.in_data   = d;
        if64.in_offset = off;
        if64.in_size   = sz;
        if64.in_sign   = sg;
        n = 0;
        @(negedge clk);
        while (!if64.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!if64.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send64_timeout: in_ready=0 after %0d cycles, required 1", n);
        end else begin
            e.data = ed;
            e.mis  = em;
            q64.push_back(e);
        end
        @(posedge clk);
        #1;
        if64.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("drain_q32_empty", 64'(q32.size()), 64'd0);
        check("drain_q64_empty", 64'(q64.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 32-bit instance: ordering, payload, counter and stall stability
    initial begin
        logic [1:0]  cnt;
        logic        stalled;
        logic [31:0] held_data;
        logic        held_mis;
        exp_t        e;
        cnt = '0;
        stalled = 1'b0;
        held_data = '0;
        held_mis = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stalled = 1'b0;
                cnt = '0;
            end else begin
                if (stalled && if32.out_valid) begin
                    check("hold32_data", 64'(if32.out_data), 64'(held_data));
                    check("hold32_mis", 64'(if32.out_misalign), 64'(held_mis));
                end
                if (if32.out_valid && if32.out_ready) begin
                    if (q32.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out32_unexpected: beat 0x%0h delivered, none expected", if32.out_data);
                    end else begin
                        e = q32.pop_front();
                        check("out32_data", 64'(if32.out_data), e.data);
                        check("out32_mis", 64'(if32.out_misalign), 64'(e.mis));
                        check("out32_errcnt", 64'(if32.err_count), 64'(cnt));
                        if (e.mis && cnt != 2'b11) cnt = cnt + 2'd1;
                    end
                end
                stalled   = if32.out_valid && !if32.out_ready;
                held_data = if32.out_data;
                held_mis  = if32.out_misalign;
            end
        end
    end

    // Monitor for the 64-bit instance
    initial begin
        logic [7:0] cnt;
        exp_t       e;
        cnt = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cnt = '0;
            end else if (if64.out_valid && if64.out_ready) begin
                if (q64.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out64_unexpected: beat 0x%0h delivered, none expected", if64.out_data);
                end else begin
                    e = q64.pop_front();
                    check("out64_data", if64.out_data, e.data);
                    check("out64_mis", 64'(if64.out_misalign), 64'(e.mis));
                    check("out64_errcnt", 64'(if64.err_count), 64'(cnt));
                    if (e.mis && cnt != 8'hFF) cnt = cnt + 8'd1;
                end
            end
        end
    end

    initial begin
        errors  = 0;
        checks  = 0;
        acc32   = 0;
        reset_n = 1'b0;
        if32.in_valid = 1'b0; if32.in_data = '0; if32.in_offset = '0;
        if32.in_size = '0; if32.in_sign = 1'b0; if32.out_ready = 1'b1;
        if64.in_valid = 1'b0; if64.in_data = '0; if64.in_offset = '0;
        if64.in_size = '0; if64.in_sign = 1'b0; if64.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_out_valid32", 64'(if32.out_valid), 64'd0);
        check("rst_out_data32", 64'(if32.out_data), 64'd0);
        check("rst_out_mis32", 64'(if32.out_misalign), 64'd0);
        check("rst_errcnt32", 64'(if32.err_count), 64'd0);
        check("rst_out_valid64", 64'(if64.out_valid), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Two beats in flight, then reset: they must never appear
        if32.out_ready = 1'b0;
        send32(32'h0000_00FF, 2'd0, 2'd0, 1'b1, 32'h0, 1'b0, 1'b0);
        send32(32'hABCD_1234, 2'd1, 2'd1, 1'b1, 32'h0, 1'b1, 1'b0);
        check("inflight_out_valid", 64'(if32.out_valid), 64'd1);
        check("inflight_in_ready", 64'(if32.in_ready), 64'd0);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(if32.out_valid), 64'd0);
        check("midrst_errcnt", 64'(if32.err_count), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        if32.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("postrst_out_valid", 64'(if32.out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Byte sign extension with latency check
        send32(32'h0000_8000, 2'd1, 2'd0, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b1);
        @(negedge clk);
        check("latency_cycle1", 64'(if32.out_valid), 64'd0);
        @(negedge clk);
        check("latency_cycle2", 64'(if32.out_valid), 64'd1);
        @(posedge clk);
        #1;
        send32(32'h0000_8000, 2'd1, 2'd0, 1'b0, 32'h0000_0080, 1'b0, 1'b1);
        send32(32'hABCD_1234, 2'd2, 2'd1, 1'b1, 32'hFFFF_ABCD, 1'b0, 1'b1);
        send32(32'hABCD_1234, 2'd1, 2'd1, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
        send32(32'h7F00_0000, 2'd3, 2'd0, 1'b1, 32'h0000_007F, 1'b0, 1'b1);
        send32(32'h89AB_CDEF, 2'd0, 2'd2, 1'b0, 32'h89AB_CDEF, 1'b0, 1'b1);
        send32(32'h0000_F00D, 2'd0, 2'd1, 1'b0, 32'h0000_F00D, 1'b0, 1'b1);
        drain();
        check("errcnt_after_half_mis", 64'(if32.err_count), 64'd1);
        check("hold_last_data", 64'(if32.out_data), 64'h0000_F00D);

        // Backpressure: out_ready low for 3 cycles while 4 beats are offered
        if32.out_ready = 1'b0;
        acc32 = 0;
        fork
            begin
                send32(32'h1122_3344, 2'd0, 2'd2, 1'b0, 32'h1122_3344, 1'b0, 1'b1);
                send32(32'h0000_00FE, 2'd0, 2'd0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
                send32(32'h5566_7788, 2'd2, 2'd1, 1'b0, 32'h0000_5566, 1'b0, 1'b1);
                send32(32'h00A5_0000, 2'd2, 2'd0, 1'b1, 32'hFFFF_FFA5, 1'b0, 1'b1);
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_in_ready_low", 64'(if32.in_ready), 64'd0);
                check("bp_accepted", 64'(acc32), 64'd2);
                @(posedge clk);
                #1;
                if32.out_ready = 1'b1;
            end
        join
        drain();

        // Saturation: four more misaligned beats take the 2-bit counter from 1 to 3
        send32(32'h1234_5678, 2'd2, 2'd2, 1'b0, 32'h0, 1'b1, 1'b1);
        send32(32'h1234_5678, 2'd0, 2'd3, 1'b0, 32'h0, 1'b1, 1'b1);
        send32(32'h1234_5678, 2'd3, 2'd1, 1'b1, 32'h0, 1'b1, 1'b1);
        send32(32'h1234_5678, 2'd1, 2'd2, 1'b1, 32'h0, 1'b1, 1'b1);
        drain();
        check("errcnt_saturated", 64'(if32.err_count), 64'd3);

        // 64-bit datapath
        send64(64'h8000_0000_0000_0000, 3'd0, 2'd3, 1'b1, 64'h8000_0000_0000_0000, 1'b0);
        send64(64'h8000_0000_0000_0000, 3'd4, 2'd2, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0);
        send64(64'h8000_0000_0000_0000, 3'd4, 2'd2, 1'b0, 64'h0000_0000_8000_0000, 1'b0);
        send64(64'h8000_0000_0000_0000, 3'd7, 2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        send64(64'h8000_0000_0000_0000, 3'd6, 2'd1, 1'b0, 64'h0000_0000_0000_8000, 1'b0);
        send64(64'h8000_0000_0000_0000, 3'd4, 2'd3, 1'b1, 64'h0, 1'b1);
        drain();
        check("errcnt64", 64'(if64.err_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
